// File: rtl/memory_if.sv
// Bus bundle for the memory block: one write port and one combinational read port.
interface memory_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4
);
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_en;
  logic [DATA_W-1:0] r_data;
  logic              r_perr;

  modport master (
    output r_addr, w_addr, w_data, w_en,
    input  r_data, r_perr
  );

  modport slave (
    input  r_addr, w_addr, w_data, w_en,
    output r_data, r_perr
  );
endinterface

// File: rtl/memory.sv
// DEPTH x DATA_W register file: synchronous write, combinational read, async clear.
// Optional per-entry even parity when MEMORY_PARITY_EN is defined.
module memory #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 64
) (
  input  logic      clk,
  input  logic      rst,
  memory_if.slave   bus
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (bus.w_en) begin
      mem_d[bus.w_addr] = bus.w_data;
    end
  end

  // Clearing every entry from rst keeps reads X-free from the first reset onward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    bus.r_data = mem_q[bus.r_addr];
  end

`ifdef MEMORY_PARITY_EN
  logic par_q [DEPTH];
  logic par_d [DEPTH];

  always_comb begin
    par_d = par_q;
    if (bus.w_en) begin
      par_d[bus.w_addr] = ^bus.w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        par_q[i] <= 1'b0;
      end
    end else begin
      par_q <= par_d;
    end
  end

  always_comb begin
    bus.r_perr = ^{mem_q[bus.r_addr], par_q[bus.r_addr]};
  end
`else
  always_comb begin
    bus.r_perr = 1'b0;
  end
`endif

endmodule

// File: tb/tb_memory.sv
`timescale 1ns/1ps
module tb_memory;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 64;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  memory_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_data(input string tag, input logic [DATA_W-1:0] exp);
    nvec++;
    assert (bus.r_data === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, bus.r_data, exp);
    end
  endtask

  task automatic check_perr(input string tag, input logic exp);
    nvec++;
    assert (bus.r_perr === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, bus.r_perr, exp);
    end
  endtask

  task automatic read_at(input logic [ADDR_W-1:0] a);
    bus.r_addr = a;
    #0.01;
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    nvec = 0;
    nerr = 0;
    rst        = 1'b0;
    bus.r_addr = '0;
    bus.w_addr = '0;
    bus.w_data = '0;
    bus.w_en   = 1'b0;

    // Reset with no clock edge yet (first posedge at 5ns)
    #1 rst = 1'b1;
    #0.5;
    read_at(6'd0);  check_data("rst_a0", 4'b0000); check_perr("rst_perr_a0", 1'b0);
    read_at(6'd17); check_data("rst_a17", 4'b0000);
    read_at(6'd63); check_data("rst_a63", 4'b0000); check_perr("rst_perr_a63", 1'b0);

    @(negedge clk);
    rst = 1'b0;

    // Basic write
    bus.w_en = 1'b1; bus.w_addr = 6'd5; bus.w_data = 4'b0100;
    @(negedge clk);
    bus.w_en = 1'b0;
    read_at(6'd5); check_data("wr_a5", 4'b0100); check_perr("wr_perr_a5", 1'b0);
    read_at(6'd6); check_data("wr_a6", 4'b0000);

    // Disabled write ignored
    bus.w_en = 1'b0; bus.w_addr = 6'd2; bus.w_data = 4'b1111;
    @(negedge clk);
    read_at(6'd2); check_data("noen_a2", 4'b0000);

    // Same-address read/write: old before edge, new after
    bus.w_en = 1'b1; bus.w_addr = 6'd63; bus.w_data = 4'b0001;
    read_at(6'd63); check_data("rw_before", 4'b0000);
    @(posedge clk);
    #1;
    check_data("rw_after", 4'b0001);
    @(negedge clk);
    bus.w_en = 1'b0;

    // Fill every address with addr[3:0]
    for (int i = 0; i < DEPTH; i++) begin
      a = 6'(i);
      bus.w_en = 1'b1; bus.w_addr = a; bus.w_data = a[3:0];
      @(negedge clk);
    end
    bus.w_en = 1'b0;
    read_at(6'd35); check_data("fill_a35", 4'b0011);
    read_at(6'd63); check_data("fill_a63", 4'b1111);
    read_at(6'd10); check_data("fill_a10", 4'b1010);

    // Mid-cycle async reset: all zero before the next edge
    #1 rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      read_at(6'(i));
      check_data("arst_all", 4'b0000);
    end
    check_perr("arst_perr", 1'b0);

    // Writes ignored while rst is high
    @(negedge clk);
    bus.w_en = 1'b1; bus.w_addr = 6'd7; bus.w_data = 4'b1010;
    @(negedge clk);
    read_at(6'd7); check_data("rst_blocks_wr", 4'b0000);

    // First write after release lands on the first edge
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_data("first_wr", 4'b1010);
    @(negedge clk);
    bus.w_en = 1'b0;
    read_at(6'd8); check_data("first_wr_a8", 4'b0000);

`ifdef MEMORY_PARITY_EN
    bus.w_en = 1'b1; bus.w_addr = 6'd9; bus.w_data = 4'b1000;
    @(negedge clk);
    bus.w_en = 1'b0;
    read_at(6'd9); check_perr("par_good", 1'b0);
    force dut.par_q[9] = 1'b0;
    #0.01;
    check_perr("par_forced", 1'b1);
    release dut.par_q[9];
    bus.w_en = 1'b1; bus.w_addr = 6'd9; bus.w_data = 4'b1000;
    @(negedge clk);
    bus.w_en = 1'b0;
    #0.01;
    check_perr("par_rewrite", 1'b0);
    check_data("par_data", 4'b1000);
`else
    read_at(6'd7); check_perr("noparity_perr", 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 Parameter ADDR_W, default 6, address width in bits.
REQ-002 Parameter DATA_W, default 4, data width in bits.
REQ-003 Parameter DEPTH, default 64, number of entries; SHALL equal 2**ADDR_W.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock; all state changes on rising edge except reset.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 r_addr  input  ADDR_W  read address.
REQ-008 w_addr  input  ADDR_W  write address.
REQ-009 w_data  input  DATA_W  write data.
REQ-010 w_en  input  1  write enable, sampled on rising clk.
REQ-011 r_data  output  DATA_W  read data for r_addr.
REQ-012 r_perr  output  1  parity error flag for the entry at r_addr.

Function
REQ-013 Storage SHALL be DEPTH entries of DATA_W bits, one independent write port and one independent read port.
REQ-014 Write: on rising clk with rst low and w_en high, entry[w_addr] SHALL take w_data; no other entry changes.
REQ-015 w_en low at rising clk: no entry changes; w_addr and w_data ignored.
REQ-016 Read SHALL be combinational, zero latency: r_data = entry[r_addr] at all times, tracking r_addr changes within the same cycle.
REQ-017 Read and write to the same address in one cycle: r_data SHALL show the old contents before the edge and the new contents immediately after it; no forwarding of w_data before the edge.
REQ-018 Every address value 0..DEPTH-1 SHALL be valid; no out-of-range address exists at ADDR_W=6/DEPTH=64.
REQ-019 r_data SHALL never be X after the first reset, for any r_addr.
REQ-020 r_perr SHALL be 0 whenever MEMORY_PARITY_EN is undefined.

Reset
REQ-021 rst high SHALL clear every entry to 0 asynchronously, without waiting for clk.
REQ-022 While rst is high, writes SHALL be ignored, even with w_en high at a rising clk.
REQ-023 During and after reset, r_data SHALL read 0 for every address until that address is written.
REQ-024 Reset asserted mid-operation SHALL discard all earlier writes.
REQ-025 First write after reset SHALL take effect at the first rising clk with rst low and w_en high.
REQ-026 After reset, r_perr SHALL be 0 for every address.

Configuration
REQ-027 Macro MEMORY_PARITY_EN defined: each entry SHALL also hold an even-parity bit, equal to the XOR of w_data, written together with the data and cleared to 0 by reset.
REQ-028 With MEMORY_PARITY_EN defined, r_perr SHALL be 1 combinationally exactly when the XOR of the stored data and stored parity bit at r_addr is 1.
REQ-029 Macro MEMORY_PARITY_EN undefined: no parity storage SHALL exist; r_perr SHALL be tied to 0; all other behaviour is identical.

Verification
REQ-030 Assert rst with no clk edge -> r_data = 4'b0000 at r_addr = 0, 17 and 63; r_perr = 0.
REQ-031 w_en=1, w_addr=5, w_data=4'b0100, one rising clk; r_addr=5 -> r_data = 4'b0100; r_addr=6 -> 4'b0000.
REQ-032 Write 4'b0001 to address 63 with r_addr=63 in the same cycle -> r_data = 4'b0000 before the edge and 4'b0001 after it.
REQ-033 w_en=0, w_addr=2, w_data=4'b1111, one rising clk -> entry 2 stays 4'b0000.
REQ-034 Fill addresses 0..63 with addr[3:0], pulse rst asynchronously mid-cycle -> all addresses read 0 immediately, before the next clk edge.
REQ-035 MEMORY_PARITY_EN defined: write 4'b1000 to address 9, force its stored parity bit to 0 -> r_addr=9 gives r_perr = 1; rewrite address 9 normally -> r_perr = 0.
